dccm_ctrl: RTL and testbench
============================

# dccm_ctrl

Data closely-coupled memory responder for the RV32I core's MEM stage. It accepts load and store requests issued by the load/store unit on the DCCM port and owns the word-wide single-port data array. Stores pass through a 2-entry store buffer that drains into the array on cycles with no load. Loads return the array word one cycle later, with pending buffered bytes forwarded over it.

## Interface
- `DEPTH`, default 4096: array size in 32-bit words; a power of 2.
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0; word-aligned.
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `dccm_rd_en_i`  in  1  load request, this cycle.
- `dccm_rd_addr_i`  in  32  load byte address. The full word at addr[31:2] is returned; the LSU does the lane shift and extension.
- `dccm_wr_en_i`  in  1  store request, this cycle.
- `dccm_wr_addr_i`  in  32  store byte address.
- `dccm_wr_data_i`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `dccm_wr_size_i`  in  2  store size: 00 byte, 01 half, 10 word; 11 is illegal.
- `dccm_rd_data_o`  out  32  load word; valid when `dccm_rd_valid_o`=1; holds its value otherwise.
- `dccm_rd_valid_o`  out  1  high exactly one cycle after an accepted load.
- `dccm_sb_full_o`  out  1  registered; store buffer holds 2 entries.
- `dccm_sb_empty_o`  out  1  registered; store buffer holds 0 entries.
- `dccm_err_o`  out  1  one-cycle pulse, the cycle after a rejected request.
- `dccm_err_addr_o`  out  32  address of the most recent rejected request; holds its value.

## Operation
**Offset and range**
- off = addr − ADDR_BASE (32-bit wrap).
- In range when off < DEPTH*4.
- Word index = off[log2(DEPTH)+1:2].

**Store acceptance**
- A store is accepted when it is in range, legal in size/alignment, and (buffer not full, or a drain happens the same cycle).
- Legal alignment: byte at any address; half needs addr[0]=0; word needs addr[1:0]=00.
- Lane placement:
  - byte: data[7:0] goes to lane addr[1:0], mask 1<<addr[1:0].
  - half: data[15:0] goes to lanes addr[1]*2 and +1, mask 4'b0011 or 4'b1100.
  - word: mask 4'b1111.
- An accepted store enqueues {word index, 32-bit lane data, 4-bit mask} at the buffer tail.

**Load acceptance**
- A load is accepted when it is in range. Alignment is not checked.
- The array is read at the word index.

**Rejection**
- Any rejected request is dropped and has no side effect: no enqueue, no array access, `dccm_rd_valid_o` not raised.
- `dccm_err_o` pulses and `dccm_err_addr_o` is loaded with the request address.
- If both requests are rejected in the same cycle, the store address is recorded.

**Port arbitration (single-port array)**
- Priority: accepted load > drain.
- Drain occurs when no load is accepted and the buffer is non-empty: the head entry is written using its byte mask and then dequeued.
- Load and store in the same cycle are both accepted; the store only enqueues.

**Forwarding**
- For an accepted load, merge in this order onto the array word: oldest buffer entry, then youngest. Each merge applies only for an entry with a matching word index, and only on that entry's mask lanes.
- Entries enqueued in the same cycle as the load are not forwarded, since the store is younger in program order.

**Buffer and reset**
- The buffer is a 2-entry FIFO with head/tail pointers and a count of 0..2.
- Count update: +1 on enqueue, −1 on drain, net 0 when both happen in one cycle.
- Reset clears the buffer: pending stores are discarded, even mid-drain.
- Array contents are not reset.

## Timing
- Load latency: address in cycle N, `dccm_rd_valid_o`=1 and data in cycle N+1. Back-to-back loads sustain 1 per cycle.
- Store-to-array latency: earliest write in cycle N+1, after enqueue in cycle N. A continuous load stream starves the drain.
- Store-to-load ordering: a load in cycle ≥ N+1 sees the store from cycle N, through forwarding or through the array.
- `dccm_sb_full_o` and `dccm_sb_empty_o` update the cycle after the enqueue or drain. The LSU must not issue a store while full unless a drain is guaranteed; an LSU that also loads that cycle sees the store rejected.
- Reset values:
  - `dccm_rd_data_o`=0, `dccm_rd_valid_o`=0, `dccm_sb_full_o`=0, `dccm_sb_empty_o`=1, `dccm_err_o`=0, `dccm_err_addr_o`=0.
  - Pointers and count are 0.
  - A load accepted in the cycle that `rst` is asserted produces no valid in the following cycle.

## Test plan
- **Word store then later load.** SW 0xDEADBEEF to 0x10, idle 2 cycles, LW 0x10 → rd_data 0xDEADBEEF with rd_valid 1 cycle after the load; sb_empty back to 1.
- **Byte forwarding.** SW 0x11223344 to 0x20, drained. Then SB 0xAA to 0x22 in cycle N and LW 0x20 in cycle N+1 → 0x11AA3344 returned from the buffer, before any drain.
- **Full buffer under load stream.**
  - Continuous loads with SB to 0x0 and 0x1 enqueued, then a third store → sb_full=1, third store rejected, err pulse, err_addr = that address.
  - After loads stop, two drains follow and sb_empty=1.
- **Illegal requests.** SH to 0x3, SW to 0x6, size 11, and LW to ADDR_BASE+DEPTH*4 → each gives a 1-cycle err pulse; the array is unchanged and no rd_valid is raised.
- **Simultaneous load and store to the same word.** LW 0x40 (holding 0x0) with SW 0x55 to 0x40 in the same cycle → load returns 0x0; next-cycle LW returns 0x00000055.
- **Reset mid-operation.** Two stores buffered, assert rst for 1 cycle → sb_empty=1, err=0, rd_valid=0; a subsequent load returns the pre-store array value.

Source files
------------

// File: rtl/dccm_ctrl_if.sv
// DCCM request/response bundle between the load/store unit (master)
// and the DCCM responder (slave).
interface dccm_ctrl_if;
    logic        dccm_rd_en_i;
    logic [31:0] dccm_rd_addr_i;
    logic        dccm_wr_en_i;
    logic [31:0] dccm_wr_addr_i;
    logic [31:0] dccm_wr_data_i;
    logic [1:0]  dccm_wr_size_i;
    logic [31:0] dccm_rd_data_o;
    logic        dccm_rd_valid_o;
    logic        dccm_sb_full_o;
    logic        dccm_sb_empty_o;
    logic        dccm_err_o;
    logic [31:0] dccm_err_addr_o;

    modport master (
        output dccm_rd_en_i, dccm_rd_addr_i,
        output dccm_wr_en_i, dccm_wr_addr_i, dccm_wr_data_i, dccm_wr_size_i,
        input  dccm_rd_data_o, dccm_rd_valid_o,
        input  dccm_sb_full_o, dccm_sb_empty_o,
        input  dccm_err_o, dccm_err_addr_o
    );

    modport slave (
        input  dccm_rd_en_i, dccm_rd_addr_i,
        input  dccm_wr_en_i, dccm_wr_addr_i, dccm_wr_data_i, dccm_wr_size_i,
        output dccm_rd_data_o, dccm_rd_valid_o,
        output dccm_sb_full_o, dccm_sb_empty_o,
        output dccm_err_o, dccm_err_addr_o
    );
endinterface

// File: rtl/dccm_ctrl.sv
// DCCM responder: word-wide single-port data array fronted by a 2-entry
// store buffer. Loads win the array port; the buffer drains on idle cycles.
// Load data is forwarded from pending buffer entries, oldest first.
module dccm_ctrl #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    dccm_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] sb_idx_q  [2];
    logic [31:0]   sb_data_q [2];
    logic [3:0]    sb_mask_q [2];
    logic          head_q, tail_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          full_q, empty_q;

    logic [31:0]   rd_data_q, err_addr_q;
    logic          rd_valid_q, err_q;

    logic [31:0]   rd_off, wr_off, fwd_word, wr_lane_data;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [3:0]    wr_mask;
    logic          rd_in_range, wr_in_range, wr_legal;
    logic          ld_acc, wr_acc, drain, rd_rej, wr_rej;
    logic          old_slot, yng_slot;
    logic [1:0]    unused_rd_off;

    assign rd_off        = bus.dccm_rd_addr_i - ADDR_BASE;
    assign wr_off        = bus.dccm_wr_addr_i - ADDR_BASE;
    assign rd_in_range   = (rd_off >> (AW + 2)) == 32'd0;
    assign wr_in_range   = (wr_off >> (AW + 2)) == 32'd0;
    assign rd_idx        = rd_off[AW+1:2];
    assign wr_idx        = wr_off[AW+1:2];
    // loads return the whole word; byte offset is the LSU's business
    assign unused_rd_off = rd_off[1:0];

    // store size/alignment legality and lane placement
    always_comb begin
        wr_legal     = 1'b0;
        wr_mask      = 4'b0000;
        wr_lane_data = bus.dccm_wr_data_i;
        case (bus.dccm_wr_size_i)
            2'b00: begin
                wr_legal     = 1'b1;
                wr_mask      = 4'b0001 << wr_off[1:0];
                wr_lane_data = {4{bus.dccm_wr_data_i[7:0]}};
            end
            2'b01: begin
                wr_legal     = ~wr_off[0];
                wr_mask      = wr_off[1] ? 4'b1100 : 4'b0011;
                wr_lane_data = {2{bus.dccm_wr_data_i[15:0]}};
            end
            2'b10: begin
                wr_legal     = wr_off[1:0] == 2'b00;
                wr_mask      = 4'b1111;
            end
            default: wr_legal = 1'b0;
        endcase
    end

    // a load always owns the port; a full buffer accepts a store only if it drains now
    assign ld_acc = bus.dccm_rd_en_i & rd_in_range;
    assign drain  = ~rst & ~ld_acc & (cnt_q != 2'd0);
    assign wr_acc = bus.dccm_wr_en_i & wr_in_range & wr_legal & ((cnt_q != 2'd2) | drain);
    assign rd_rej = bus.dccm_rd_en_i & ~rd_in_range;
    assign wr_rej = bus.dccm_wr_en_i & ~wr_acc;

    assign old_slot = head_q;
    assign yng_slot = ~head_q;

    // buffer occupancy after this cycle's enqueue/drain
    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc && !drain)
            cnt_d = cnt_q + 2'd1;
        else if (!wr_acc && drain)
            cnt_d = cnt_q - 2'd1;
    end

    // array word with pending stores merged in, oldest then youngest
    always_comb begin
        fwd_word = mem_q[rd_idx];
        if (cnt_q != 2'd0 && sb_idx_q[old_slot] == rd_idx) begin
            for (int b = 0; b < 4; b++)
                if (sb_mask_q[old_slot][b])
                    fwd_word[8*b +: 8] = sb_data_q[old_slot][8*b +: 8];
        end
        if (cnt_q == 2'd2 && sb_idx_q[yng_slot] == rd_idx) begin
            for (int b = 0; b < 4; b++)
                if (sb_mask_q[yng_slot][b])
                    fwd_word[8*b +: 8] = sb_data_q[yng_slot][8*b +: 8];
        end
    end

    // array write from the buffer head, byte-masked; contents survive reset
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++)
                if (sb_mask_q[head_q][b])
                    mem_q[sb_idx_q[head_q]][8*b +: 8] <= sb_data_q[head_q][8*b +: 8];
        end
    end

    // buffer entry payload at the tail
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            sb_idx_q[tail_q]  <= wr_idx;
            sb_data_q[tail_q] <= wr_lane_data;
            sb_mask_q[tail_q] <= wr_mask;
        end
    end

    // buffer pointers, count and registered full/empty flags
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            cnt_q   <= 2'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_acc) tail_q <= ~tail_q;
            if (drain)  head_q <= ~head_q;
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == 2'd2;
            empty_q <= cnt_d == 2'd0;
        end
    end

    // load response and error reporting; store address wins a double reject
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            rd_valid_q <= ld_acc;
            if (ld_acc) rd_data_q <= fwd_word;
            err_q <= rd_rej | wr_rej;
            if (wr_rej)
                err_addr_q <= bus.dccm_wr_addr_i;
            else if (rd_rej)
                err_addr_q <= bus.dccm_rd_addr_i;
        end
    end

    assign bus.dccm_rd_data_o  = rd_data_q;
    assign bus.dccm_rd_valid_o = rd_valid_q;
    assign bus.dccm_sb_full_o  = full_q;
    assign bus.dccm_sb_empty_o = empty_q;
    assign bus.dccm_err_o      = err_q;
    assign bus.dccm_err_addr_o = err_addr_q;
endmodule

// File: tb/tb_dccm_ctrl.sv
// Directed bench for dccm_ctrl with default parameters (4096 words at 0x0).
module tb_dccm_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    dccm_ctrl_if bus ();

    dccm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic re, input logic [31:0] ra,
                         input logic we, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] ws);
        bus.dccm_rd_en_i   = re;
        bus.dccm_rd_addr_i = ra;
        bus.dccm_wr_en_i   = we;
        bus.dccm_wr_addr_i = wa;
        bus.dccm_wr_data_i = wd;
        bus.dccm_wr_size_i = ws;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_rd_data",  bus.dccm_rd_data_o,        32'h0);
        chk("rst_rd_valid", 32'(bus.dccm_rd_valid_o),  32'h0);
        chk("rst_full",     32'(bus.dccm_sb_full_o),   32'h0);
        chk("rst_empty",    32'(bus.dccm_sb_empty_o),  32'h1);
        chk("rst_err",      32'(bus.dccm_err_o),       32'h0);
        chk("rst_err_addr", bus.dccm_err_addr_o,       32'h0);
        rst = 1'b0;

        // known contents for words 0x0 and 0x40
        drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 2'b10);  tick();
        idle();                                          tick();
        drive(1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 2'b10); tick();
        idle();                                          tick();

        // word store, later load
        drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10); tick();
        chk("sw_empty_after_enq", 32'(bus.dccm_sb_empty_o), 32'h0);
        idle(); tick();
        chk("sw_empty_after_drain", 32'(bus.dccm_sb_empty_o), 32'h1);
        idle(); tick();
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("lw10_valid", 32'(bus.dccm_rd_valid_o), 32'h1);
        chk("lw10_data",  bus.dccm_rd_data_o, 32'hDEADBEEF);
        idle(); tick();
        chk("lw10_valid_drop", 32'(bus.dccm_rd_valid_o), 32'h0);
        chk("lw10_data_hold",  bus.dccm_rd_data_o, 32'hDEADBEEF);

        // byte forwarding from the buffer
        drive(1'b0, 32'h0, 1'b1, 32'h20, 32'h11223344, 2'b10); tick();
        idle(); tick();
        drive(1'b0, 32'h0, 1'b1, 32'h22, 32'h000000AA, 2'b00); tick();
        drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("fwd_sb_valid", 32'(bus.dccm_rd_valid_o), 32'h1);
        chk("fwd_sb_data",  bus.dccm_rd_data_o, 32'h11AA3344);
        chk("fwd_sb_pending", 32'(bus.dccm_sb_empty_o), 32'h0);
        idle(); tick();
        chk("fwd_sb_drained", 32'(bus.dccm_sb_empty_o), 32'h1);

        // same-cycle load and store to one word
        drive(1'b1, 32'h40, 1'b1, 32'h40, 32'h55, 2'b10); tick();
        chk("ldst_same_old", bus.dccm_rd_data_o, 32'h0);
        drive(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("ldst_next_new", bus.dccm_rd_data_o, 32'h00000055);
        idle(); tick();

        // full buffer under a load stream
        drive(1'b1, 32'h10, 1'b1, 32'h0, 32'h01, 2'b00); tick();
        chk("stream_empty", 32'(bus.dccm_sb_empty_o), 32'h0);
        drive(1'b1, 32'h10, 1'b1, 32'h1, 32'h02, 2'b00); tick();
        chk("stream_full", 32'(bus.dccm_sb_full_o), 32'h1);
        drive(1'b1, 32'h10, 1'b1, 32'h2, 32'h03, 2'b00); tick();
        chk("full_rej_err",  32'(bus.dccm_err_o), 32'h1);
        chk("full_rej_addr", bus.dccm_err_addr_o, 32'h2);
        chk("full_ld_data",  bus.dccm_rd_data_o, 32'hDEADBEEF);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("full_err_pulse", 32'(bus.dccm_err_o), 32'h0);
        chk("fwd_two_entries", bus.dccm_rd_data_o, 32'h00000201);
        chk("still_full", 32'(bus.dccm_sb_full_o), 32'h1);
        idle(); tick();
        chk("drain1_full",  32'(bus.dccm_sb_full_o), 32'h0);
        chk("drain1_empty", 32'(bus.dccm_sb_empty_o), 32'h0);
        idle(); tick();
        chk("drain2_empty", 32'(bus.dccm_sb_empty_o), 32'h1);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("array_after_drain", bus.dccm_rd_data_o, 32'h00000201);

        // illegal requests
        drive(1'b0, 32'h0, 1'b1, 32'h3, 32'hFFFF, 2'b01); tick();
        chk("sh_mis_err",   32'(bus.dccm_err_o), 32'h1);
        chk("sh_mis_addr",  bus.dccm_err_addr_o, 32'h3);
        chk("sh_mis_empty", 32'(bus.dccm_sb_empty_o), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 32'h6, 32'hFFFFFFFF, 2'b10); tick();
        chk("sw_mis_err",  32'(bus.dccm_err_o), 32'h1);
        chk("sw_mis_addr", bus.dccm_err_addr_o, 32'h6);
        drive(1'b0, 32'h0, 1'b1, 32'h8, 32'hFFFFFFFF, 2'b11); tick();
        chk("size11_addr", bus.dccm_err_addr_o, 32'h8);
        drive(1'b1, 32'h4000, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("lw_oor_err",   32'(bus.dccm_err_o), 32'h1);
        chk("lw_oor_addr",  bus.dccm_err_addr_o, 32'h4000);
        chk("lw_oor_valid", 32'(bus.dccm_rd_valid_o), 32'h0);
        drive(1'b1, 32'h4000, 1'b1, 32'h6, 32'h0, 2'b10); tick();
        chk("both_rej_addr", bus.dccm_err_addr_o, 32'h6);
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("illegal_no_change", bus.dccm_rd_data_o, 32'h00000201);
        chk("illegal_err_clear", 32'(bus.dccm_err_o), 32'h0);

        // reset with two stores pending, load issued in the reset cycle
        drive(1'b1, 32'h0, 1'b1, 32'h10, 32'h12345678, 2'b10); tick();
        drive(1'b1, 32'h0, 1'b1, 32'h14, 32'h00000009, 2'b10); tick();
        chk("pre_rst_full", 32'(bus.dccm_sb_full_o), 32'h1);
        rst = 1'b1;
        drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("mid_rst_empty",    32'(bus.dccm_sb_empty_o), 32'h1);
        chk("mid_rst_full",     32'(bus.dccm_sb_full_o), 32'h0);
        chk("mid_rst_err",      32'(bus.dccm_err_o), 32'h0);
        chk("mid_rst_valid",    32'(bus.dccm_rd_valid_o), 32'h0);
        chk("mid_rst_err_addr", bus.dccm_err_addr_o, 32'h0);
        rst = 1'b0;
        idle(); tick();
        chk("rst_cycle_load_dropped", 32'(bus.dccm_rd_valid_o), 32'h0);
        drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 2'b00); tick();
        chk("post_rst_valid", 32'(bus.dccm_rd_valid_o), 32'h1);
        chk("post_rst_data",  bus.dccm_rd_data_o, 32'hDEADBEEF);
        idle(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
